// File: rtl/ir_byte_fetch.sv
// Two-byte instruction fetch sequencer: reads BaseAddr and BaseAddr+1 from byte memory,
// loads each byte into the downstream 16-bit Register and presents the assembled word.
module ir_byte_fetch #(
    parameter int ADDR_W    = 16,
    parameter int RD_LAT    = 1,
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] BaseAddr,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemRd,
    input  logic [7:0]        MemData,
    output logic [15:0]       RegI,
    output logic              RegE,
    output logic [2:0]        RegFunSel,
    output logic [15:0]       Word,
    output logic              Busy,
    output logic              Done
);

    typedef enum logic [2:0] {
        IDLE,
        RD1,
        WAIT1,
        LD1,
        RD2,
        WAIT2,
        LD2,
        DONE
    } state_t;

    localparam logic [2:0] FS_LO     = 3'b101;
    localparam logic [2:0] FS_HI     = 3'b110;
    localparam logic [2:0] FIRST_FS  = LOW_FIRST ? FS_LO : FS_HI;
    localparam logic [2:0] SECOND_FS = LOW_FIRST ? FS_HI : FS_LO;
    localparam logic [1:0] CNT_LAST  = 2'(RD_LAT - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [7:0]          b1_q, b1_d;
    logic [7:0]          b2_q, b2_d;
    logic [15:0]         word_q, word_d;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            cnt_q       <= '0;
            b1_q        <= '0;
            b2_q        <= '0;
            word_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            cnt_q       <= cnt_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            word_q      <= word_d;
        end
    end

    // Next-state logic; the WAIT states capture MemData only on their final cycle.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        cnt_d       = cnt_q;
        b1_d        = b1_q;
        b2_d        = b2_q;
        word_d      = word_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    addr_d  = BaseAddr;
                    word_d  = '0;
                    state_d = RD1;
                end
            end
            RD1: begin
                last_addr_d = addr_q;
                state_d     = WAIT1;
            end
            WAIT1: begin
                if (cnt_q == CNT_LAST) begin
                    b1_d    = MemData;
                    cnt_d   = '0;
                    state_d = LD1;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            LD1: state_d = RD2;
            RD2: begin
                last_addr_d = addr_q + ADDR_W'(1);
                state_d     = WAIT2;
            end
            WAIT2: begin
                if (cnt_q == CNT_LAST) begin
                    b2_d    = MemData;
                    cnt_d   = '0;
                    state_d = LD2;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            LD2: begin
                word_d  = LOW_FIRST ? {b2_q, b1_q} : {b1_q, b2_q};
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs; MemAddr falls back to the last address actually driven.
    always_comb begin
        MemAddr   = last_addr_q;
        MemRd     = 1'b0;
        RegI      = 16'h0000;
        RegE      = 1'b0;
        RegFunSel = 3'b000;
        Word      = word_q;
        Busy      = (state_q != IDLE);
        Done      = 1'b0;
        case (state_q)
            RD1: begin
                MemRd   = 1'b1;
                MemAddr = addr_q;
            end
            RD2: begin
                MemRd   = 1'b1;
                MemAddr = addr_q + ADDR_W'(1);
            end
            LD1: begin
                RegE      = 1'b1;
                RegFunSel = FIRST_FS;
                RegI      = {8'h00, b1_q};
            end
            LD2: begin
                RegE      = 1'b1;
                RegFunSel = SECOND_FS;
                RegI      = {8'h00, b2_q};
            end
            DONE:    Done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ir_byte_fetch.sv
// Directed bench for ir_byte_fetch: two instances (RD_LAT=1/LOW_FIRST=1 and RD_LAT=3/LOW_FIRST=0)
// with a latency-accurate memory model and an event scoreboard.
module tb_ir_byte_fetch;

    localparam logic [1:0] K_RD = 2'd1;
    localparam logic [1:0] K_LD = 2'd2;
    localparam logic [1:0] K_DN = 2'd3;

    typedef struct {
        int         cyc;
        logic [1:0] kind;
        logic [18:0] val;
    } exp_t;

    logic        Clock;
    logic        Reset_a, Reset_b, Start_a, Start_b;
    logic [15:0] BaseAddr_a, BaseAddr_b, MemAddr_a, MemAddr_b;
    logic        MemRd_a, MemRd_b;
    logic [7:0]  MemData_a, MemData_b;
    logic [15:0] RegI_a, RegI_b, Word_a, Word_b;
    logic        RegE_a, RegE_b, Busy_a, Busy_b, Done_a, Done_b;
    logic [2:0]  RegFunSel_a, RegFunSel_b;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t exp_a[$];
    exp_t exp_b[$];

    logic [16:0] pipe_a;
    logic [16:0] pipe_b [3];
    logic [7:0]  junk_a, junk_b;
    logic [15:0] reg_q;

    ir_byte_fetch #(.ADDR_W(16), .RD_LAT(1), .LOW_FIRST(1'b1)) dut_a (
        .Clock(Clock), .Reset(Reset_a), .Start(Start_a), .BaseAddr(BaseAddr_a),
        .MemAddr(MemAddr_a), .MemRd(MemRd_a), .MemData(MemData_a),
        .RegI(RegI_a), .RegE(RegE_a), .RegFunSel(RegFunSel_a),
        .Word(Word_a), .Busy(Busy_a), .Done(Done_a)
    );

    ir_byte_fetch #(.ADDR_W(16), .RD_LAT(3), .LOW_FIRST(1'b0)) dut_b (
        .Clock(Clock), .Reset(Reset_b), .Start(Start_b), .BaseAddr(BaseAddr_b),
        .MemAddr(MemAddr_b), .MemRd(MemRd_b), .MemData(MemData_b),
        .RegI(RegI_b), .RegE(RegE_b), .RegFunSel(RegFunSel_b),
        .Word(Word_b), .Busy(Busy_b), .Done(Done_b)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [7:0] memRead(input logic [15:0] a);
        case (a)
            16'h0010: return 8'h34;
            16'h0011: return 8'h12;
            16'hFFFF: return 8'hAA;
            16'h0000: return 8'h55;
            16'h0100: return 8'h9C;
            16'h0101: return 8'h01;
            16'h0200: return 8'h5A;
            16'h0201: return 8'hC3;
            16'h0202: return 8'h7E;
            default:  return 8'hEE;
        endcase
    endfunction

    // Memory returns data RD_LAT cycles after the read strobe, random junk otherwise.
    always @(posedge Clock) begin
        cyc       <= cyc + 1;
        pipe_a    <= {MemRd_a, MemAddr_a};
        pipe_b[0] <= {MemRd_b, MemAddr_b};
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
        junk_a    <= 8'($urandom);
        junk_b    <= 8'($urandom);
    end
    assign MemData_a = pipe_a[16]    ? memRead(pipe_a[15:0])    : junk_a;
    assign MemData_b = pipe_b[2][16] ? memRead(pipe_b[2][15:0]) : junk_b;

    // Downstream 16-bit Register fed by dut_a.
    always @(posedge Clock) begin
        if (RegE_a) begin
            case (RegFunSel_a)
                3'b101:  reg_q[7:0]  <= RegI_a[7:0];
                3'b110:  reg_q[15:8] <= RegI_a[7:0];
                default: ;
            endcase
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic observe(input int which, input logic [1:0] kind, input logic [18:0] val);
        exp_t e;
        int   pending;
        pending = (which == 0) ? exp_a.size() : exp_b.size();
        checkOutput(which == 0 ? "event_expected_a" : "event_expected_b", 64'(pending > 0), 64'd1);
        if (pending > 0) begin
            if (which == 0) e = exp_a.pop_front();
            else            e = exp_b.pop_front();
            checkOutput("event_kind",  64'(kind), 64'(e.kind));
            checkOutput("event_cycle", 64'(cyc),  64'(e.cyc));
            checkOutput("event_value", 64'(val),  64'(e.val));
        end
    endtask

    always @(negedge Clock) begin
        if (MemRd_a) observe(0, K_RD, {3'b000, MemAddr_a});
        if (RegE_a)  observe(0, K_LD, {RegFunSel_a, RegI_a});
        if (Done_a)  observe(0, K_DN, {3'b000, Word_a});
        if (MemRd_b) observe(1, K_RD, {3'b000, MemAddr_b});
        if (RegE_b)  observe(1, K_LD, {RegFunSel_b, RegI_b});
        if (Done_b)  observe(1, K_DN, {3'b000, Word_b});
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
        #1;
    endtask

    // Pushes the expected event sequence for a fetch and pulses Start for one cycle.
    task automatic applyStimulus(input int which, input logic [15:0] base, input int n_ev);
        int          lat;
        bit          lf;
        logic [7:0]  b0, b1;
        logic [2:0]  fs1, fs2;
        logic [15:0] w;
        int          t;
        exp_t        ev[5];
        lat = (which == 0) ? 1 : 3;
        lf  = (which == 0);
        b0  = memRead(base);
        b1  = memRead(16'(base + 16'd1));
        fs1 = lf ? 3'b101 : 3'b110;
        fs2 = lf ? 3'b110 : 3'b101;
        w   = lf ? {b1, b0} : {b0, b1};
        t   = cyc;
        ev[0] = '{t + 1,           K_RD, {3'b000, base}};
        ev[1] = '{t + 2 + lat,     K_LD, {fs1, 8'h00, b0}};
        ev[2] = '{t + 3 + lat,     K_RD, {3'b000, 16'(base + 16'd1)}};
        ev[3] = '{t + 4 + 2 * lat, K_LD, {fs2, 8'h00, b1}};
        ev[4] = '{t + 5 + 2 * lat, K_DN, {3'b000, w}};
        for (int i = 0; i < n_ev; i++) begin
            if (which == 0) exp_a.push_back(ev[i]);
            else            exp_b.push_back(ev[i]);
        end
        if (which == 0) begin
            Start_a = 1'b1; BaseAddr_a = base;
            tick(1);
            Start_a = 1'b0;
        end else begin
            Start_b = 1'b1; BaseAddr_b = base;
            tick(1);
            Start_b = 1'b0;
        end
    endtask

    task automatic waitIdle(input int which, input int budget);
        int n;
        int left;
        logic busy;
        n = 0;
        do begin
            tick(1);
            n++;
            left = (which == 0) ? exp_a.size() : exp_b.size();
            busy = (which == 0) ? Busy_a : Busy_b;
        end while ((left != 0 || busy) && n < budget);
        checkOutput(which == 0 ? "drain_a" : "drain_b", 64'({left, busy}), 64'd0);
    endtask

    initial begin
        Reset_a = 1'b1; Reset_b = 1'b1;
        Start_a = 1'b0; Start_b = 1'b0;
        BaseAddr_a = 16'h0000; BaseAddr_b = 16'h0000;
        tick(3);
        checkOutput("reset_outputs_a",
            64'({MemAddr_a, MemRd_a, RegI_a, RegE_a, RegFunSel_a, Word_a, Busy_a, Done_a}), 64'd0);
        checkOutput("reset_outputs_b",
            64'({MemAddr_b, MemRd_b, RegI_b, RegE_b, RegFunSel_b, Word_b, Busy_b, Done_b}), 64'd0);
        Reset_a = 1'b0; Reset_b = 1'b0;
        tick(2);

        $display("[TB] basic fetch, RD_LAT=1 LOW_FIRST=1");
        applyStimulus(0, 16'h0010, 5);
        waitIdle(0, 40);
        tick(2);
        checkOutput("register_q_basic", 64'(reg_q), 64'h1234);
        checkOutput("word_hold_basic", 64'(Word_a), 64'h1234);
        checkOutput("memaddr_hold_basic", 64'(MemAddr_a), 64'h0011);

        $display("[TB] address wrap at FFFF");
        applyStimulus(0, 16'hFFFF, 5);
        waitIdle(0, 40);
        checkOutput("word_wrap", 64'(Word_a), 64'h55AA);
        checkOutput("memaddr_hold_wrap", 64'(MemAddr_a), 64'h0000);

        $display("[TB] RD_LAT=3 LOW_FIRST=0");
        applyStimulus(1, 16'h0100, 5);
        waitIdle(1, 60);
        checkOutput("word_lat3", 64'(Word_b), 64'h9C01);

        $display("[TB] Start while busy is ignored, Start after Done accepted");
        applyStimulus(0, 16'h0200, 5);
        tick(1);
        Start_a = 1'b1; BaseAddr_a = 16'h0010;
        tick(1);
        Start_a = 1'b0;
        tick(4);
        checkOutput("done_at_retrigger", 64'(Done_a), 64'd1);
        Start_a = 1'b1; BaseAddr_a = 16'h0300;
        tick(1);
        applyStimulus(0, 16'h0201, 5);
        checkOutput("word_cleared_on_start", 64'(Word_a), 64'd0);
        waitIdle(0, 40);
        checkOutput("word_retrigger", 64'(Word_a), 64'h7EC3);

        $display("[TB] Reset during WAIT2");
        applyStimulus(0, 16'h0010, 3);
        tick(4);
        Reset_a = 1'b1;
        tick(1);
        checkOutput("reset_mid_fetch",
            64'({MemAddr_a, MemRd_a, RegI_a, RegE_a, RegFunSel_a, Word_a, Busy_a, Done_a}), 64'd0);
        Reset_a = 1'b0;
        tick(5);
        checkOutput("no_ld2_after_reset", 64'(reg_q), 64'h7E34);
        checkOutput("events_after_reset", 64'(exp_a.size()), 64'd0);
        applyStimulus(0, 16'h0010, 5);
        waitIdle(0, 40);
        checkOutput("word_after_reset", 64'(Word_a), 64'h1234);

        $display("[TB] Reset and Start together");
        Reset_a = 1'b1; Start_a = 1'b1; BaseAddr_a = 16'h0010;
        tick(1);
        checkOutput("busy_reset_start", 64'(Busy_a), 64'd0);
        Reset_a = 1'b0; Start_a = 1'b0;
        tick(1);
        checkOutput("busy_after_reset_start", 64'(Busy_a), 64'd0);
        tick(6);
        checkOutput("idle_after_reset_start", 64'({Busy_a, MemRd_a}), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
